// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// UART receive path: a 2-flop line synchroniser, a receive FSM with 3-sample
// majority voting per bit, and a first-word-fall-through FIFO. Each FIFO entry
// holds one frame's data plus its parity-error and stop-error flags.
//
// Ports
//   rx_clk            receive clock, all state on the rising edge
//   res_n             asynchronous active-low reset
//   prescale_in       rx_clk cycles per bit (4..2^PRESCALE_WIDTH-1), latched per frame
//   s_data_in         serial line, idle high, asynchronous to rx_clk
//   par_en_in         1 = a parity bit follows the data bits (latched per frame)
//   par_typ_in        0 = even, 1 = odd parity (latched per frame)
//   stop2_in          1 = two stop bits (latched per frame)
//   rd_en_in          pop the head entry, ignored when the FIFO is empty
//   p_data_out        head entry data, 0 when empty
//   parity_error_out  head entry parity flag, 0 when empty
//   stop_error_out    head entry stop flag, 0 when empty
//   data_valid_out    FIFO not empty
//   fifo_count_out    number of occupied entries
//   overrun_out       one-cycle pulse: a completed frame was dropped, FIFO full
module uart_rx_fifo #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 5,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                            rx_clk,
    input  logic                            res_n,
    input  logic [PRESCALE_WIDTH-1:0]       prescale_in,
    input  logic                            s_data_in,
    input  logic                            par_en_in,
    input  logic                            par_typ_in,
    input  logic                            stop2_in,
    input  logic                            rd_en_in,
    output logic [DATA_WIDTH-1:0]           p_data_out,
    output logic                            parity_error_out,
    output logic                            stop_error_out,
    output logic                            data_valid_out,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count_out,
    output logic                            overrun_out
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int PW  = PRESCALE_WIDTH;
    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam int WW  = DATA_WIDTH + 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Received parity is in error when data XOR parity bit differs from the
    // selected type (0 = even, 1 = odd).
    function automatic logic parity_err(input logic [DATA_WIDTH-1:0] d,
                                        input logic pbit, input logic odd);
        return ((^d) ^ pbit) != odd;
    endfunction

    logic                  sync1_r;
    logic                  line_r;
    state_t                state_r;
    state_t                state_nx_s;
    logic [PW-1:0]         p_r;
    logic                  par_en_r;
    logic                  par_typ_r;
    logic                  stop2_r;
    logic [PW-1:0]         cnt_r;
    logic [BCW-1:0]        bit_cnt_r;
    logic [1:0]            smp_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  par_err_r;
    logic                  stop_err_r;

    logic [PW-1:0]         half_s;
    logic                  vote_s;
    logic                  decide_s;
    logic                  bit_end_s;
    logic                  start_s;
    logic                  push_s;
    logic [WW-1:0]         push_word_s;

    // The third vote is the live line value at the decision count.
    assign half_s      = p_r >> 1;
    assign vote_s      = maj3(smp_r[0], smp_r[1], line_r);
    assign decide_s    = (state_r != ST_IDLE) && (cnt_r == (half_s + PW'(1)));
    assign bit_end_s   = (cnt_r == (p_r - PW'(1)));
    assign push_word_s = {shift_r, par_err_r, stop_err_r | ~vote_s};

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge rx_clk or negedge res_n) begin
        if (!res_n) begin
            sync1_r <= 1'b1;
            line_r  <= 1'b1;
        end else begin
            sync1_r <= s_data_in;
            line_r  <= sync1_r;
        end
    end

    // FSM state register.
    always_ff @(posedge rx_clk or negedge res_n) begin
        if (!res_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state, frame-start and push strobes.
    always_comb begin
        state_nx_s = state_r;
        start_s    = 1'b0;
        push_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!line_r) begin
                    start_s    = 1'b1;
                    state_nx_s = ST_START;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (decide_s) begin
                    state_nx_s = vote_s ? ST_IDLE : ST_DATA;
                end else begin
                    state_nx_s = ST_START;
                end
            end
            ST_DATA: begin
                if (decide_s && (bit_cnt_r == BCW'(DATA_WIDTH - 1))) begin
                    state_nx_s = par_en_r ? ST_PARITY : ST_STOP;
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (decide_s) begin
                    state_nx_s = ST_STOP;
                end else begin
                    state_nx_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                // Push and return to IDLE at the last stop-bit decision so a
                // following start edge is seen on the very next cycle.
                if (decide_s && (bit_cnt_r == (stop2_r ? BCW'(1) : BCW'(0)))) begin
                    push_s     = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_STOP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Receive datapath: frame config latch, bit timing, sampling and shifting.
    // The detection cycle itself is count 0, so the counter restarts at 1.
    always_ff @(posedge rx_clk or negedge res_n) begin
        if (!res_n) begin
            p_r        <= '0;
            par_en_r   <= 1'b0;
            par_typ_r  <= 1'b0;
            stop2_r    <= 1'b0;
            cnt_r      <= '0;
            bit_cnt_r  <= '0;
            smp_r      <= 2'b11;
            shift_r    <= '0;
            par_err_r  <= 1'b0;
            stop_err_r <= 1'b0;
        end else if (start_s) begin
            p_r        <= prescale_in;
            par_en_r   <= par_en_in;
            par_typ_r  <= par_typ_in;
            stop2_r    <= stop2_in;
            cnt_r      <= PW'(1);
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            par_err_r  <= 1'b0;
            stop_err_r <= 1'b0;
        end else if (state_r != ST_IDLE) begin
            cnt_r <= bit_end_s ? PW'(0) : (cnt_r + PW'(1));
            if (cnt_r == (half_s - PW'(1))) begin
                smp_r[0] <= line_r;
            end
            if (cnt_r == half_s) begin
                smp_r[1] <= line_r;
            end
            if (decide_s) begin
                case (state_r)
                    ST_DATA: begin
                        shift_r   <= {vote_s, shift_r[DATA_WIDTH-1:1]};
                        bit_cnt_r <= (bit_cnt_r == BCW'(DATA_WIDTH - 1)) ?
                                     BCW'(0) : (bit_cnt_r + BCW'(1));
                    end
                    ST_PARITY: begin
                        par_err_r <= parity_err(shift_r, vote_s, par_typ_r);
                    end
                    ST_STOP: begin
                        stop_err_r <= stop_err_r | ~vote_s;
                        bit_cnt_r  <= bit_cnt_r + BCW'(1);
                    end
                    default: begin
                        bit_cnt_r <= '0;
                    end
                endcase
            end
        end
    end

    // ---------------- receive FIFO ----------------
    logic [WW-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [WW-1:0] head_r;
    logic          valid_r;
    logic          overrun_r;

    logic          pop_s;
    logic          push_ok_s;
    logic          drop_s;
    logic [AW-1:0] wr_ptr_nx_s;
    logic [AW-1:0] rd_ptr_nx_s;
    logic [CW-1:0] count_nx_s;
    logic [WW-1:0] head_nx_s;

    // FIFO next-state. When full, a simultaneous pop frees the slot first, so
    // the push is accepted. The head is precomputed so outputs are registered.
    always_comb begin
        pop_s       = rd_en_in && (count_r != CW'(0));
        push_ok_s   = push_s && ((count_r != CW'(FIFO_DEPTH)) || pop_s);
        drop_s      = push_s && !push_ok_s;
        wr_ptr_nx_s = push_ok_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
        rd_ptr_nx_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_nx_s = count_r + CW'(1);
            2'b01:   count_nx_s = count_r - CW'(1);
            default: count_nx_s = count_r;
        endcase
        if (count_nx_s == CW'(0)) begin
            head_nx_s = '0;
        end else if (push_ok_s && (rd_ptr_nx_s == wr_ptr_r)) begin
            head_nx_s = push_word_s;
        end else begin
            head_nx_s = mem_r[rd_ptr_nx_s];
        end
    end

    // FIFO storage, pointers and registered head/status.
    always_ff @(posedge rx_clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            head_r    <= '0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_word_s;
            end
            wr_ptr_r  <= wr_ptr_nx_s;
            rd_ptr_r  <= rd_ptr_nx_s;
            count_r   <= count_nx_s;
            head_r    <= head_nx_s;
            valid_r   <= (count_nx_s != CW'(0));
            overrun_r <= drop_s;
        end
    end

    assign p_data_out       = head_r[WW-1:2];
    assign parity_error_out = head_r[1];
    assign stop_error_out   = head_r[0];
    assign data_valid_out   = valid_r;
    assign fifo_count_out   = count_r;
    assign overrun_out      = overrun_r;

endmodule
